seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a NUM_DIGITS-digit common-select 7-segment display.

---
 rtl/seven_seg_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller for a NUM_DIGITS-digit 7-segment display.
//   One shared BCD decoder is fed from bcd_out. digit_en is a one-hot digit
//   select. Each digit slot is PRESCALE clocks long: BLANK_CYCLES blanked
//   clocks, then the digit is shown for the rest of the slot. A new display
//   word is taken over valid/ready into a pending register. It becomes the
//   active (displayed) word only at a frame wrap, so a frame never mixes the
//   nibbles of two different words.
//
//   Optional feature macro: SEG_LZB_EN (leading-zero blanking).
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous reset, active low
//   in_valid     in_word is valid
//   in_ready     controller can accept in_word this cycle
//   in_word      BCD digits, [3:0] = digit 0 (least significant)
//   bcd_out      BCD nibble of the current digit
//   digit_en     one-hot digit select, all zero while blanked
//   frame_start  one-cycle pulse in the first cycle of a new frame
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_word,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int WW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] slot_cnt, cnt_nxt;
    logic [IW-1:0] digit_idx, idx_nxt;
    logic [WW-1:0] active, active_nxt;
    logic [WW-1:0] pending, pending_nxt;
    logic          pending_full, pf_nxt;
    logic          drain, drain_nxt;
    logic          slot_end, wrap, xfer, lit;
    logic [NUM_DIGITS-1:0]      en_nxt;
    logic [NUM_DIGITS-1:0][3:0] active_nib;

`ifdef SEG_LZB_EN
    logic [IW-1:0] msd, msd_nxt;

    // Index of the most significant nonzero nibble; nibbles >9 count as nonzero.
    function automatic logic [IW-1:0] msd_of(input logic [WW-1:0] w);
        msd_of = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (w[4*i +: 4] != 4'd0) msd_of = IW'(i);
    endfunction
`endif

    // Next-state and registered-output values.
    always_comb begin
        slot_end = (slot_cnt == CNT_LAST);
        wrap     = slot_end && (digit_idx == IDX_LAST);
        cnt_nxt  = slot_end ? '0 : slot_cnt + CW'(1);
        idx_nxt  = digit_idx;
        if (slot_end) idx_nxt = wrap ? '0 : digit_idx + IW'(1);

        state_nxt = state;
        case (state)
            BLANK:   if (cnt_nxt == CNT_SHOW) state_nxt = SHOW;
            SHOW:    if (slot_end)            state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase

        // The active word swaps at the wrap edge so that digit 0 of the new
        // frame already shows it. The pending slot is released one cycle later
        // (drain), which keeps in_ready low through the frame_start cycle. A
        // word accepted on the wrap edge itself only lands in pending.
        xfer        = in_valid && in_ready;
        active_nxt  = active;
        pending_nxt = pending;
        pf_nxt      = pending_full;
        drain_nxt   = drain;
        if (drain) begin
            pf_nxt    = 1'b0;
            drain_nxt = 1'b0;
        end
        if (wrap && pending_full && !drain) begin
            active_nxt = pending;
            drain_nxt  = 1'b1;
        end
        if (xfer) begin
            pending_nxt = in_word;
            pf_nxt      = 1'b1;
        end

`ifdef SEG_LZB_EN
        msd_nxt = wrap ? msd_of(active_nxt) : msd;
        lit     = (idx_nxt <= msd_nxt);
`else
        lit     = 1'b1;
`endif
        en_nxt = '0;
        if (state_nxt == SHOW && lit) en_nxt = NUM_DIGITS'(1) << idx_nxt;

        active_nib = active_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BLANK;
            slot_cnt     <= '0;
            digit_idx    <= '0;
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            drain        <= 1'b0;
            in_ready     <= 1'b1;
            digit_en     <= '0;
            bcd_out      <= 4'd0;
            frame_start  <= 1'b0;
`ifdef SEG_LZB_EN
            msd          <= '0;
`endif
        end else begin
            state        <= state_nxt;
            slot_cnt     <= cnt_nxt;
            digit_idx    <= idx_nxt;
            active       <= active_nxt;
            pending      <= pending_nxt;
            pending_full <= pf_nxt;
            drain        <= drain_nxt;
            in_ready     <= ~pf_nxt;
            digit_en     <= en_nxt;
            bcd_out      <= active_nib[idx_nxt];
            frame_start  <= wrap;
`ifdef SEG_LZB_EN
            msd          <= msd_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=8,
// BLANK_CYCLES=2). Cycle 0 is the first cycle after the reset edge; a frame
// is 32 cycles, a slot 8 cycles (2 blank + 6 shown).
module tb_seven_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_word = '0;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .bcd_out(bcd_out), .digit_en(digit_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Digits lit for a displayed word: all four, or up to the highest
    // nonzero nibble when leading-zero blanking is built in.
    function automatic logic [3:0] lit_mask(input logic [15:0] w);
`ifdef SEG_LZB_EN
        int m = 0;
        for (int i = 0; i < 4; i++) if (w[4*i +: 4] != 4'd0) m = i;
        lit_mask = 4'((1 << (m + 1)) - 1);
`else
        lit_mask = 4'hf;
`endif
    endfunction

    function automatic logic [3:0] exp_en(input int c, input logic [15:0] w);
        int slot = (c / 8) % 4;
        logic [3:0] m = lit_mask(w);
        exp_en = ((c % 8) >= 2 && m[slot]) ? 4'(1 << slot) : 4'b0;
    endfunction

    function automatic logic [3:0] exp_bcd(input int c, input logic [15:0] w);
        int slot = (c / 8) % 4;
        exp_bcd = w[4*slot +: 4];
    endfunction

    function automatic logic [15:0] frame_word(input int c, input logic [15:0] f0,
                                               input logic [15:0] f1, input logic [15:0] f2);
        frame_word = (c < 32) ? f0 : (c < 64) ? f1 : f2;
    endfunction

    // Leaves the bench inside cycle 0, before its negedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; in_word = 16'h5555;
        do_reset();
        @(negedge clk);
        vectors += 4;
        if (digit_en !== 4'b0) begin miscompares++; $display("FAIL reset_en got %b expected 0000", digit_en); end
        if (bcd_out !== 4'd0) begin miscompares++; $display("FAIL reset_bcd got %h expected 0", bcd_out); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b expected 1", in_ready); end
        if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs got %b expected 0", frame_start); end
    endtask

    task automatic test_scan();
        do_reset();
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            vectors += 3;
            if (digit_en !== exp_en(c, 16'h0)) begin miscompares++;
                $display("FAIL scan_en cyc %0d got %b expected %b", c, digit_en, exp_en(c, 16'h0)); end
            if (bcd_out !== 4'd0) begin miscompares++;
                $display("FAIL scan_bcd cyc %0d got %h expected 0", c, bcd_out); end
            if (frame_start !== (c == 32)) begin miscompares++;
                $display("FAIL scan_fs cyc %0d got %b expected %b", c, frame_start, c == 32); end
        end
    endtask

    task automatic test_update();
        logic [15:0] w;
        do_reset();
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            w = frame_word(c, 16'h0, 16'h4321, 16'h4321);
            vectors += 2;
            if (digit_en !== exp_en(c, w)) begin miscompares++;
                $display("FAIL upd_en cyc %0d got %b expected %b", c, digit_en, exp_en(c, w)); end
            if (bcd_out !== exp_bcd(c, w)) begin miscompares++;
                $display("FAIL upd_bcd cyc %0d got %h expected %h", c, bcd_out, exp_bcd(c, w)); end
            if (c <= 5 || (c >= 6 && c <= 31) || c >= 33) begin
                vectors++;
                if (in_ready !== (c <= 5 || c >= 33)) begin miscompares++;
                    $display("FAIL upd_ready cyc %0d got %b expected %b", c, in_ready, c <= 5 || c >= 33); end
            end
            in_valid = (c == 5);
            in_word  = (c == 5) ? 16'h4321 : 16'h0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int stage = 0;
        int acc0 = -1, acc1 = -1;
        do_reset();
        for (int c = 0; c < 96; c++) begin
            @(negedge clk);
            w = frame_word(c, 16'h0, 16'h1111, 16'h2222);
            vectors += 2;
            if (digit_en !== exp_en(c, w)) begin miscompares++;
                $display("FAIL b2b_en cyc %0d got %b expected %b", c, digit_en, exp_en(c, w)); end
            if (bcd_out !== exp_bcd(c, w)) begin miscompares++;
                $display("FAIL b2b_bcd cyc %0d got %h expected %h", c, bcd_out, exp_bcd(c, w)); end
            if (c >= 5 && stage < 2) begin
                in_valid = 1'b1;
                in_word  = (stage == 0) ? 16'h1111 : 16'h2222;
                if (in_ready === 1'b1) begin
                    if (stage == 0) acc0 = c; else acc1 = c;
                    stage++;
                end
            end else begin
                in_valid = 1'b0;
                in_word  = 16'h0;
            end
        end
        in_valid = 1'b0;
        vectors += 2;
        if (acc0 != 5) begin miscompares++; $display("FAIL b2b_acc0 got cyc %0d expected 5", acc0); end
        if (acc1 != 33) begin miscompares++; $display("FAIL b2b_acc1 got cyc %0d expected 33", acc1); end
    endtask

    task automatic test_wrap_edge();
        logic [15:0] w;
        do_reset();
        for (int c = 0; c < 96; c++) begin
            @(negedge clk);
            w = frame_word(c, 16'h0, 16'h0, 16'h9876);
            vectors += 2;
            if (digit_en !== exp_en(c, w)) begin miscompares++;
                $display("FAIL wrap_en cyc %0d got %b expected %b", c, digit_en, exp_en(c, w)); end
            if (bcd_out !== exp_bcd(c, w)) begin miscompares++;
                $display("FAIL wrap_bcd cyc %0d got %h expected %h", c, bcd_out, exp_bcd(c, w)); end
            if (c == 31 || c == 32 || c == 50 || c == 65) begin
                vectors++;
                if (in_ready !== (c == 31 || c == 65)) begin miscompares++;
                    $display("FAIL wrap_ready cyc %0d got %b expected %b", c, in_ready, c == 31 || c == 65); end
            end
            in_valid = (c == 31);
            in_word  = (c == 31) ? 16'h9876 : 16'h0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            in_valid = (c == 5);
            in_word  = (c == 5) ? 16'h4321 : 16'h0;
            if (c == 20) begin
                vectors++;
                if (digit_en !== 4'b0100) begin miscompares++;
                    $display("FAIL mrst_pre_en got %b expected 0100", digit_en); end
                rst_n = 1'b0;
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            vectors += 4;
            if (digit_en !== exp_en(c, 16'h0)) begin miscompares++;
                $display("FAIL mrst_en cyc %0d got %b expected %b", c, digit_en, exp_en(c, 16'h0)); end
            if (bcd_out !== 4'd0) begin miscompares++;
                $display("FAIL mrst_bcd cyc %0d got %h expected 0", c, bcd_out); end
            if (in_ready !== 1'b1) begin miscompares++;
                $display("FAIL mrst_ready cyc %0d got %b expected 1", c, in_ready); end
            if (frame_start !== (c == 32)) begin miscompares++;
                $display("FAIL mrst_fs cyc %0d got %b expected %b", c, frame_start, c == 32); end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] w;
        do_reset();
        for (int c = 0; c < 96; c++) begin
            @(negedge clk);
            w = frame_word(c, 16'h0, 16'h0050, 16'h0000);
            vectors += 2;
            if (digit_en !== exp_en(c, w)) begin miscompares++;
                $display("FAIL lzb_en cyc %0d got %b expected %b", c, digit_en, exp_en(c, w)); end
            if (bcd_out !== exp_bcd(c, w)) begin miscompares++;
                $display("FAIL lzb_bcd cyc %0d got %h expected %h", c, bcd_out, exp_bcd(c, w)); end
            in_valid = (c == 5 || c == 40);
            in_word  = (c == 5) ? 16'h0050 : 16'h0000;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_back_to_back();
        test_wrap_edge();
        test_mid_reset();
        test_leading_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
